// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl -- on-chip self-test initiator for the my_mem port.
//
// A run writes NUM_WORDS LFSR-generated bytes to BASE_ADDR + i*ADDR_STRIDE,
// idles for one cycle, reads the same words back in reverse order and compares
// each returned word against the byte remembered in a small scoreboard.
//
// Ports:
//   clk          system clock, everything on the rising edge
//   rst          asynchronous active-high reset
//   start        launches a run when seen in IDLE or DONE
//   busy         high from the first write cycle to the last drain cycle
//   done         high in DONE until the next run launches
//   pass         result of the run while done=1 (error_count == 0)
//   error_count  saturating mismatch count
//   fail_addr    address of the first mismatch of the run, 0 if none
//   write/read   memory strobes
//   address      memory address
//   data_in      memory write data
//   data_out     memory read data, bit 8 is the parity of bits 7:0
//
// Build option:
//   MEM_BIST_PARITY_CHECK_EN  when defined the parity bit data_out[8] is
//                             compared as well; otherwise it is ignored.

module mem_bist_ctrl #(
  parameter int          NUM_WORDS   = 6,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [15:0] ADDR_STRIDE = 16'h0001,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  error_count,
  output logic [15:0] fail_addr,
  output logic        write,
  output logic        read,
  output logic [15:0] address,
  output logic [7:0]  data_in,
  input  logic [8:0]  data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // One counter serves as write index, read index and drain counter, so it
  // must hold both NUM_WORDS-1 and READ_LAT-1 (at most 3).
  localparam int IDX_W = ($clog2(NUM_WORDS) > 2) ? $clog2(NUM_WORDS) : 2;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] DRAIN_LAST = IDX_W'(READ_LAT - 1);

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pat_q, pat_d;       // pattern of the word written next
  logic             write_q, write_d;
  logic             read_q, read_d;
  logic [15:0]      address_q, address_d;
  logic [7:0]       data_in_q, data_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      fail_addr_q, fail_addr_d;

  // Scoreboard of written bytes; read port is registered and addressed with
  // the next index so the byte is ready while its read strobe is out.
  logic [7:0] sb_mem [2**IDX_W];
  logic [7:0] sb_rdata_q;

  // Compare pipeline: stage 0 is loaded at the edge where the memory takes
  // the read strobe, the last stage lines up with the returned data_out.
  logic [READ_LAT-1:0] pv_q;
  logic [7:0]          pexp_q  [READ_LAT];
  logic [15:0]         paddr_q [READ_LAT];

  logic        tail_valid;
  logic [7:0]  tail_exp;
  logic        mismatch;

  assign tail_valid = pv_q[READ_LAT-1];
  assign tail_exp   = pexp_q[READ_LAT-1];

`ifdef MEM_BIST_PARITY_CHECK_EN
  assign mismatch = (data_out != {^tail_exp, tail_exp});
`else
  logic unused_parity_bit;
  assign unused_parity_bit = data_out[8];
  assign mismatch = (data_out[7:0] != tail_exp);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    address_d   = address_q;
    data_in_d   = data_in_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;

    if (tail_valid && mismatch) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      // The count never returns to zero within a run, so zero means "first".
      if (err_q == 8'd0) fail_addr_d = paddr_q[READ_LAT-1];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          idx_d       = '0;
          write_d     = 1'b1;
          address_d   = BASE_ADDR;
          data_in_d   = SEED;
          pat_d       = lfsr_next(SEED);
          err_d       = 8'd0;
          fail_addr_d = 16'd0;
        end
      end
      S_WRITE: begin
        if (idx_q != LAST_IDX) begin
          idx_d     = idx_q + IDX_W'(1);
          write_d   = 1'b1;
          address_d = address_q + ADDR_STRIDE;
          data_in_d = pat_q;
          pat_d     = lfsr_next(pat_q);
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // address still holds the last written word, the first one read back
        state_d = S_READ;
        read_d  = 1'b1;
        idx_d   = LAST_IDX;
      end
      S_READ: begin
        if (idx_q != '0) begin
          idx_d     = idx_q - IDX_W'(1);
          read_d    = 1'b1;
          address_d = address_q - ADDR_STRIDE;
        end else begin
          state_d = S_DRAIN;
          idx_d   = DRAIN_LAST;
        end
      end
      S_DRAIN: begin
        if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
        else             state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WRITE) || (state_d == S_GAP) ||
             (state_d == S_READ)  || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pat_q       <= SEED;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      address_q   <= 16'd0;
      data_in_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      fail_addr_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      write_q     <= write_d;
      read_q      <= read_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_d) sb_mem[idx_d] <= data_in_d;
    sb_rdata_q <= sb_mem[idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pexp_q[i]  <= 8'd0;
        paddr_q[i] <= 16'd0;
      end
    end else begin
      pv_q[0]    <= read_q;
      pexp_q[0]  <= sb_rdata_q;
      paddr_q[0] <= address_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pexp_q[i]  <= pexp_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign error_count = err_q;
  assign fail_addr   = fail_addr_q;
  assign write       = write_q;
  assign read        = read_q;
  assign address     = address_q;
  assign data_in     = data_in_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (defaults, and an address-wrap
// configuration with READ_LAT=3), each driven by a memory responder that can
// flip chosen bits of the returned word. A cycle-offset model predicts every
// output on every cycle; directed tests add literal expectations.
module tb_mem_bist_ctrl;
  localparam int          N0 = 6, L0 = 1, N1 = 4, L1 = 3;
  localparam logic [15:0] B0 = 16'h0000, B1 = 16'hFFFE;
  localparam logic [15:0] S0 = 16'h0001, S1 = 16'h0001;
`ifdef MEM_BIST_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_s = 2'b00;
  logic [1:0] busy_s, done_s, pass_s, write_s, read_s;
  logic [7:0]  err_s  [2];
  logic [15:0] fail_s [2];
  logic [15:0] addr_s [2];
  logic [7:0]  din_s  [2];
  logic [8:0]  dout_s [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .error_count(err_s[0]), .fail_addr(fail_s[0]),
    .write(write_s[0]), .read(read_s[0]), .address(addr_s[0]),
    .data_in(din_s[0]), .data_out(dout_s[0])
  );

  mem_bist_ctrl #(.NUM_WORDS(N1), .BASE_ADDR(B1), .ADDR_STRIDE(S1), .READ_LAT(L1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .error_count(err_s[1]), .fail_addr(fail_s[1]),
    .write(write_s[1]), .read(read_s[1]), .address(addr_s[1]),
    .data_in(din_s[1]), .data_out(dout_s[1])
  );

  // ---------------- corruption config, model helpers ----------------
  logic [15:0] corr_a [2][2];
  logic [8:0]  corr_m [2][2];

  function automatic int nw(input int u);  return (u == 0) ? N0 : N1; endfunction
  function automatic int lat(input int u); return (u == 0) ? L0 : L1; endfunction

  function automatic logic [15:0] addr_of(input int u, input int i);
    logic [31:0] t;
    t = (u == 0) ? (32'(B0) + 32'(i) * 32'(S0)) : (32'(B1) + 32'(i) * 32'(S1));
    return t[15:0];
  endfunction

  function automatic logic [7:0] pat_of(input int i);
    logic [7:0] p;
    p = 8'hA5;
    for (int k = 0; k < i; k++) p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    return p;
  endfunction

  function automatic logic [8:0] corr_mask(input int u, input logic [15:0] a);
    logic [8:0] m;
    m = 9'h000;
    for (int s = 0; s < 2; s++)
      if (corr_m[u][s] != 9'h000 && corr_a[u][s] == a) m = m ^ corr_m[u][s];
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [7:0] mem   [2][65536];
  logic [8:0] rpipe [2][4];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (write_s[u]) mem[u][addr_s[u]] <= din_s[u];
      rpipe[u][0] <= read_s[u] ? ({^mem[u][addr_s[u]], mem[u][addr_s[u]]} ^ corr_mask(u, addr_s[u]))
                               : 9'h000;
      for (int s = 1; s < 4; s++) rpipe[u][s] <= rpipe[u][s-1];
    end
  end
  assign dout_s[0] = rpipe[0][L0-1];
  assign dout_s[1] = rpipe[1][L1-1];

  // ---------------- behavioural model ----------------
  // phase: 0 idle after reset, 1 running (cycle index m_cyc from 1), 2 done
  int          m_phase [2] = '{0, 0};
  int          m_cyc   [2] = '{0, 0};
  logic [15:0] hold_addr [2] = '{16'h0, 16'h0};
  logic [7:0]  hold_din  [2] = '{8'h0, 8'h0};
  logic [7:0]  e_err  [2] = '{8'h0, 8'h0};
  logic [15:0] e_fail [2] = '{16'h0, 16'h0};

  task automatic model_launch(input int u);
    logic [8:0]  m;
    logic [15:0] a;
    e_err[u]  = 8'd0;
    e_fail[u] = 16'd0;
    for (int j = 0; j < nw(u); j++) begin
      a = addr_of(u, nw(u) - 1 - j);
      m = corr_mask(u, a) & (PAR_EN ? 9'h1FF : 9'h0FF);
      if (m != 9'h000) begin
        if (e_err[u] == 8'd0) e_fail[u] = a;
        if (e_err[u] != 8'hFF) e_err[u] = e_err[u] + 8'd1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_phase[u] = 0; m_cyc[u] = 0;
        hold_addr[u] = 16'd0; hold_din[u] = 8'd0;
        e_err[u] = 8'd0; e_fail[u] = 16'd0;
      end else begin
        if (m_phase[u] == 1) begin
          m_cyc[u]++;
          if (m_cyc[u] == 2 * nw(u) + 2 + lat(u)) m_phase[u] = 2;
        end else if (start_s[u]) begin
          m_phase[u] = 1;
          m_cyc[u]   = 1;
          model_launch(u);
        end
        if (m_phase[u] == 1) begin
          if (m_cyc[u] <= nw(u)) begin
            hold_addr[u] = addr_of(u, m_cyc[u] - 1);
            hold_din[u]  = pat_of(m_cyc[u] - 1);
          end else if (m_cyc[u] >= nw(u) + 2 && m_cyc[u] <= 2 * nw(u) + 1) begin
            hold_addr[u] = addr_of(u, 2 * nw(u) + 1 - m_cyc[u]);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + transaction log ----------------
  logic [15:0] wr_a [2][16];
  logic [7:0]  wr_d [2][16];
  logic [15:0] rd_a [2][16];
  int wr_n [2] = '{0, 0};
  int rd_n [2] = '{0, 0};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit run, wr, rd;
      run = (m_phase[u] == 1);
      wr  = run && m_cyc[u] <= nw(u);
      rd  = run && m_cyc[u] >= nw(u) + 2 && m_cyc[u] <= 2 * nw(u) + 1;
      chk($sformatf("u%0d c%0d busy", u, m_cyc[u]),  32'(busy_s[u]),  32'(run));
      chk($sformatf("u%0d c%0d done", u, m_cyc[u]),  32'(done_s[u]),  32'(m_phase[u] == 2));
      chk($sformatf("u%0d c%0d write", u, m_cyc[u]), 32'(write_s[u]), 32'(wr));
      chk($sformatf("u%0d c%0d read", u, m_cyc[u]),  32'(read_s[u]),  32'(rd));
      chk($sformatf("u%0d c%0d address", u, m_cyc[u]), 32'(addr_s[u]), 32'(hold_addr[u]));
      chk($sformatf("u%0d c%0d data_in", u, m_cyc[u]), 32'(din_s[u]),  32'(hold_din[u]));
      if (!run) begin
        chk($sformatf("u%0d error_count", u), 32'(err_s[u]),  32'(e_err[u]));
        chk($sformatf("u%0d fail_addr", u),   32'(fail_s[u]), 32'(e_fail[u]));
        chk($sformatf("u%0d pass", u), 32'(pass_s[u]), 32'(m_phase[u] == 2 && e_err[u] == 8'd0));
      end
      if (write_s[u] && wr_n[u] < 16) begin
        wr_a[u][wr_n[u]] = addr_s[u]; wr_d[u][wr_n[u]] = din_s[u]; wr_n[u]++;
      end
      if (read_s[u] && rd_n[u] < 16) begin
        rd_a[u][rd_n[u]] = addr_s[u]; rd_n[u]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_logs();
    wr_n[0] = 0; wr_n[1] = 0; rd_n[0] = 0; rd_n[1] = 0;
  endtask

  // Waits (bounded) for done, counting busy cycles; optionally pulses start
  // for one cycle during the first read cycle.
  task automatic wait_done(input int u, input bit pulse_in_read, inout int bcnt);
    int guard;
    bit pulsed;
    guard = 0;
    pulsed = 1'b0;
    @(negedge clk);
    while (!done_s[u] && guard < 200) begin
      if (busy_s[u]) bcnt++;
      if (pulse_in_read && read_s[u] && !pulsed) begin
        start_s[u] = 1'b1; pulsed = 1'b1;
      end else if (pulse_in_read) begin
        start_s[u] = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    checks++;
    if (!done_s[u]) begin
      errors++;
      $display("FAIL u%0d done timeout: got done=0 after %0d cycles, expected done=1", u, guard);
    end
    $display("run u%0d: busy_cycles=%0d error_count=%0d first_bad_addr=%04h pass=%0d",
             u, bcnt, err_s[u], fail_s[u], pass_s[u]);
  endtask

  task automatic run_once(input int u, input bit pulse_in_read, output int bcnt);
    bcnt = 0;
    clear_logs();
    @(posedge clk); #2 start_s[u] = 1'b1;
    @(posedge clk); #2 start_s[u] = 1'b0;
    wait_done(u, pulse_in_read, bcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic [15:0] wrap_addrs [4];
    wrap_addrs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int u = 0; u < 2; u++)
      for (int s = 0; s < 2; s++) begin corr_a[u][s] = 16'h0; corr_m[u][s] = 9'h0; end

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // model pins
    chk("model pat(1)", 32'(pat_of(1)), 32'h4A);
    chk("model pat(2)", 32'(pat_of(2)), 32'h95);
    chk("model wrap addr(2)", 32'(addr_of(1, 2)), 32'h0000);

    // clean run
    run_once(0, 1'b0, bc);
    chk("clean busy cycles", bc, 14);
    chk("clean pass", 32'(pass_s[0]), 1);
    chk("clean error_count", 32'(err_s[0]), 0);
    chk("clean fail_addr", 32'(fail_s[0]), 0);
    chk("clean wr_d0", 32'(wr_d[0][0]), 32'hA5);
    chk("clean wr_d1", 32'(wr_d[0][1]), 32'h4A);
    chk("clean wr_d2", 32'(wr_d[0][2]), 32'h95);
    for (int i = 0; i < 6; i++) chk($sformatf("clean wr_a%0d", i), 32'(wr_a[0][i]), i);
    for (int i = 0; i < 6; i++) chk($sformatf("clean rd_a%0d", i), 32'(rd_a[0][i]), 5 - i);

    // data corruption at addresses 3 and 1
    corr_a[0][0] = 16'h0003; corr_m[0][0] = 9'h001;
    corr_a[0][1] = 16'h0001; corr_m[0][1] = 9'h001;
    run_once(0, 1'b0, bc);
    chk("data err_count", 32'(err_s[0]), 2);
    chk("data fail_addr", 32'(fail_s[0]), 32'h0003);
    chk("data pass", 32'(pass_s[0]), 0);

    // parity corruption at address 0
    corr_a[0][0] = 16'h0000; corr_m[0][0] = 9'h100;
    corr_a[0][1] = 16'h0000; corr_m[0][1] = 9'h000;
    run_once(0, 1'b0, bc);
    chk("parity err_count", 32'(err_s[0]), PAR_EN ? 1 : 0);
    chk("parity pass", 32'(pass_s[0]), PAR_EN ? 0 : 1);
    corr_m[0][0] = 9'h000;

    // address wrap on the second instance
    run_once(1, 1'b0, bc);
    chk("wrap busy cycles", bc, 12);
    chk("wrap pass", 32'(pass_s[1]), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap wr_a%0d", i), 32'(wr_a[1][i]), 32'(wrap_addrs[i]));
    for (int i = 0; i < 4; i++) chk($sformatf("wrap rd_a%0d", i), 32'(rd_a[1][i]), 32'(wrap_addrs[3 - i]));

    // start pulsed during READ is ignored
    run_once(0, 1'b1, bc);
    chk("read-start busy cycles", bc, 14);
    chk("read-start pass", 32'(pass_s[0]), 1);

    // start held high through DONE relaunches on the next cycle
    bc = 0;
    @(posedge clk); #2 start_s[0] = 1'b1;
    wait_done(0, 1'b0, bc);
    chk("held done", 32'(done_s[0]), 1);
    @(posedge clk); #2 start_s[0] = 1'b0;
    @(negedge clk);
    chk("relaunch busy", 32'(busy_s[0]), 1);
    chk("relaunch done", 32'(done_s[0]), 0);
    chk("relaunch write", 32'(write_s[0]), 1);
    chk("relaunch address", 32'(addr_s[0]), 32'h0000);
    chk("relaunch data_in", 32'(din_s[0]), 32'hA5);
    bc = 1;
    wait_done(0, 1'b0, bc);
    chk("relaunch busy cycles", bc, 14);
    chk("relaunch pass", 32'(pass_s[0]), 1);

    // reset in the 3rd write cycle
    @(posedge clk); #2 start_s[0] = 1'b1;
    @(posedge clk); #2 start_s[0] = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 chk("3rd write address", 32'(addr_s[0]), 32'h0002);
    #1 rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy_s[0]), 0);
    chk("rst write", 32'(write_s[0]), 0);
    chk("rst read", 32'(read_s[0]), 0);
    chk("rst done", 32'(done_s[0]), 0);
    chk("rst pass", 32'(pass_s[0]), 0);
    chk("rst address", 32'(addr_s[0]), 0);
    chk("rst data_in", 32'(din_s[0]), 0);
    chk("rst error_count", 32'(err_s[0]), 0);
    chk("rst fail_addr", 32'(fail_s[0]), 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_once(0, 1'b0, bc);
    chk("post-rst busy cycles", bc, 14);
    chk("post-rst pass", 32'(pass_s[0]), 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
